// File: rtl/mod_probe.sv
// Burst read initiator: reads consecutive words from a combinational responder into a FWFT FIFO.
// Optional first-word id check is enabled by defining PROBE_CHECK_ID_EN.
module mod_probe #(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] EXPECT_ID = 32'hdeadbeef
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] base,
    input  logic [3:0]  count,
    output logic        busy,
    output logic        done,
    output logic        de,
    output logic [31:0] daddr,
    input  logic [31:0] din,
    output logic        q_valid,
    output logic [31:0] q_data,
    input  logic        q_ready,
    output logic        id_err
);

    localparam int             PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_OCC = (PTR_W + 1)'(DEPTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_READ = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [31:0]      addr_q, addr_d;
    logic [4:0]       remain_q, remain_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   occ_q, occ_d;
    logic [31:0]      last_q, last_d;
    logic [31:0]      mem [DEPTH];

    logic push, pop, full, abort;

    assign full    = (occ_q == FULL_OCC);
    assign push    = (state_q == S_READ) && !full;
    assign q_valid = (occ_q != '0);
    assign pop     = q_valid && q_ready;

    assign busy    = (state_q != S_IDLE);
    assign done    = (state_q == S_DONE);
    assign de      = push;
    // Address stays visible while stalled on a full FIFO.
    assign daddr   = (state_q == S_READ) ? addr_q : 32'd0;
    assign q_data  = q_valid ? mem[rd_ptr_q] : last_q;

    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        state_d  = state_q;
        addr_d   = addr_q;
        remain_d = remain_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    addr_d   = base;
                    remain_d = (count == 4'd0) ? 5'd16 : {1'b0, count};
                    state_d  = S_READ;
                end
            end
            S_READ: begin
                if (push) begin
                    addr_d   = addr_q + 32'd4;
                    remain_d = remain_q - 5'd1;
                    if (remain_q == 5'd1 || abort) state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        last_d   = pop ? mem[rd_ptr_q] : last_q;
        case ({push, pop})
            2'b10:   occ_d = occ_q + 1'b1;
            2'b01:   occ_d = occ_q - 1'b1;
            default: occ_d = occ_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            remain_q <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            last_q   <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            remain_q <= remain_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            last_q   <= last_d;
        end
    end

    // NOTE: storage is not reset; occupancy gates visibility and last_q supplies q_data when empty.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= din;
    end

`ifdef PROBE_CHECK_ID_EN
    logic id_err_q, id_err_d;
    logic first_q, first_d;

    assign abort  = push && first_q && (din != EXPECT_ID);
    assign id_err = id_err_q;

    always_comb begin
        id_err_d = id_err_q;
        first_d  = first_q;
        if (state_q == S_IDLE && start) begin
            id_err_d = 1'b0;
            first_d  = 1'b1;
        end else if (push) begin
            first_d = 1'b0;
            if (abort) id_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            id_err_q <= 1'b0;
            first_q  <= 1'b0;
        end else begin
            id_err_q <= id_err_d;
            first_q  <= first_d;
        end
    end
`else
    logic unused_expect_id;

    assign abort            = 1'b0;
    assign id_err           = 1'b0;
    assign unused_expect_id = ^EXPECT_ID;
`endif

endmodule

// File: tb/tb_mod_probe.sv
// Directed bench for mod_probe: basic burst, backpressure, address wrap, reset abort, id check.
module tb_mod_probe;

    logic        clk = 1'b0;
    logic        rst, start, q_ready;
    logic [31:0] base;
    logic [3:0]  count;
    logic        busy, done, de, q_valid, id_err;
    logic [31:0] daddr, din, q_data;
    int          mode;
    int          n_vec = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    mod_probe #(.DEPTH(4), .EXPECT_ID(32'hdeadbeef)) dut (
        .clk(clk), .rst(rst), .start(start), .base(base), .count(count),
        .busy(busy), .done(done), .de(de), .daddr(daddr), .din(din),
        .q_valid(q_valid), .q_data(q_data), .q_ready(q_ready), .id_err(id_err)
    );

    // Responder model: table 0 = board id/freq, 1 = address pattern, 2 = wrong id.
    always_comb begin
        case (mode)
            0:       din = (daddr == 32'd0) ? 32'hdeadbeef : (daddr == 32'd4) ? 32'h017d7840 : 32'd0;
            1:       din = daddr ^ 32'h5a000000;
            default: din = (daddr == 32'd0) ? 32'h12345678 : (daddr == 32'd4) ? 32'h0000cafe : 32'd0;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic kick(input logic [31:0] b, input logic [3:0] c);
        base  = b;
        count = c;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] wexp [3];
        int k;
        int nd;

        rst = 1'b1; start = 1'b0; q_ready = 1'b0; base = '0; count = '0; mode = 0;
        tick(); tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_de", de, 0);
        check("rst_daddr", daddr, 0);
        check("rst_qvalid", q_valid, 0);
        check("rst_qdata", q_data, 0);
        check("rst_iderr", id_err, 0);
        rst = 1'b0;
        tick();

        // Basic burst
        q_ready = 1'b1;
        kick(32'd0, 4'd2);
        check("b_busy", busy, 1);
        check("b_de0", de, 1);
        check("b_addr0", daddr, 32'd0);
        check("b_done0", done, 0);
        tick();
        check("b_de1", de, 1);
        check("b_addr1", daddr, 32'd4);
        check("b_q0", q_data, 32'hdeadbeef);
        tick();
        check("b_done", done, 1);
        check("b_de_off", de, 0);
        check("b_daddr_off", daddr, 0);
        check("b_q1", q_data, 32'h017d7840);
        tick();
        check("b_done_off", done, 0);
        check("b_idle", busy, 0);
        check("b_empty", q_valid, 0);
        check("b_hold", q_data, 32'h017d7840);

        // Backpressure: 16 words into a 4-deep FIFO
        mode = 1; q_ready = 1'b0;
        kick(32'h100, 4'd0);
        for (int i = 0; i < 4; i++) begin
            check("bp_de", de, 1);
            check("bp_addr", daddr, 32'h100 + 32'(4 * i));
            tick();
        end
        check("bp_stall_de", de, 0);
        check("bp_hold_addr", daddr, 32'h110);
        check("bp_head", q_data, 32'h5a000100);
        tick();
        check("bp_stall_de2", de, 0);
        q_ready = 1'b1;
        check("bp_pop_no_unblock", de, 0);
        k = 0; nd = 0;
        for (int c = 0; c < 200; c++) begin
            if (c == 1) begin
                check("bp_resume_de", de, 1);
                check("bp_resume_addr", daddr, 32'h110);
            end
            if (q_valid) begin
                check("bp_word", q_data, (32'h100 + 32'(4 * k)) ^ 32'h5a000000);
                k++;
            end
            if (done) nd++;
            if (!busy && !q_valid) break;
            tick();
        end
        check("bp_words", k, 16);
        check("bp_done_cnt", nd, 1);

        // Address wrap
        wexp[0] = 32'hfffffff8; wexp[1] = 32'hfffffffc; wexp[2] = 32'h00000000;
        kick(32'hfffffff8, 4'd3);
        for (int i = 0; i < 3; i++) begin
            check("w_de", de, 1);
            check("w_addr", daddr, wexp[i]);
            tick();
        end
        check("w_done", done, 1);
        tick();
        check("w_empty", q_valid, 0);
        check("w_last", q_data, 32'h5a000000);

        // Start ignored while busy, then reset mid-burst
        kick(32'h200, 4'd8);
        base  = 32'h900;
        start = 1'b1;
        check("s_addr0", daddr, 32'h200);
        tick();
        start = 1'b0;
        check("s_ignored", daddr, 32'h204);
        tick();
        check("s_third", daddr, 32'h208);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("r_de", de, 0);
        check("r_busy", busy, 0);
        check("r_qvalid", q_valid, 0);
        check("r_done", done, 0);
        tick();
        check("r_done2", done, 0);
        check("r_de2", de, 0);

`ifdef PROBE_CHECK_ID_EN
        mode = 2; q_ready = 1'b0;
        kick(32'd0, 4'd2);
        check("id_de", de, 1);
        check("id_addr", daddr, 32'd0);
        tick();
        check("id_done", done, 1);
        check("id_de_off", de, 0);
        check("id_err_set", id_err, 1);
        check("id_qvalid", q_valid, 1);
        check("id_qdata", q_data, 32'h12345678);
        tick();
        check("id_sticky", id_err, 1);
        check("id_done_off", done, 0);
        check("id_idle", busy, 0);
        q_ready = 1'b1;
        tick();
        mode = 0;
        kick(32'd0, 4'd2);
        check("id_clr", id_err, 0);
        check("id_ok_addr0", daddr, 32'd0);
        tick();
        check("id_ok_de1", de, 1);
        check("id_ok_addr1", daddr, 32'd4);
        tick();
        check("id_ok_done", done, 1);
        check("id_ok_q1", q_data, 32'h017d7840);
        check("id_ok_err", id_err, 0);
`else
        mode = 2; q_ready = 1'b1;
        kick(32'd0, 4'd2);
        check("noid_addr0", daddr, 32'd0);
        tick();
        check("noid_de1", de, 1);
        check("noid_addr1", daddr, 32'd4);
        check("noid_q0", q_data, 32'h12345678);
        tick();
        check("noid_done", done, 1);
        check("noid_err", id_err, 0);
`endif
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
